// File: rtl/sw_mailbox_ctrl.sv
// sw_mailbox_ctrl: fabric side of the Nios<->fabric PIO mailbox (sig handshake, shadow bank, result capture).
// Build option MBOX_DOUBLE_BUFFER_EN: writes land in a pending bank that is released to bank_out on frame_sync.
module sw_mailbox_ctrl #(
   parameter int NUM_PORTS      = 16,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int ERRCNT_W       = 8
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic [1:0]                    to_hw_sig,
   input  logic [NUM_PORTS*DATA_W-1:0]   to_hw_port_bus,
   input  logic [31:0]                   res0_in,
   input  logic [31:0]                   res1_in,
   input  logic [7:0]                    res2_in,
   input  logic                          bank_lock,
   input  logic                          frame_sync,
   output logic [1:0]                    to_sw_sig,
   output logic [31:0]                   to_sw_port0,
   output logic [31:0]                   to_sw_port1,
   output logic [7:0]                    to_sw_port2,
   output logic [NUM_PORTS*DATA_W-1:0]   bank_out,
   output logic                          bank_update,
   output logic                          busy,
   output logic [ERRCNT_W-1:0]           err_count
);

   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_READ  = 2'b10;
   localparam logic [1:0] CMD_CLEAR = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_ACK    = 2'b01;
   localparam logic [1:0] ST_RVALID = 2'b10;
   localparam logic [1:0] ST_ERR    = 2'b11;

   localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WLATCH,
      S_CLR,
      S_RLATCH,
      S_WACK,
      S_RACK,
      S_ERR
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [1:0]         sig_next;
   logic [1:0]         to_sw_sig_reg;
   logic               busy_reg;
   logic [ERRCNT_W-1:0] err_count_reg;
   logic [31:0]        port0_reg, port1_reg;
   logic [7:0]         port2_reg;
   logic               bank_update_reg;

   logic               load_bank;
   logic               load_zero;
   logic               load_res;
   logic               err_entry;
   logic               capture_ok;
   logic               bank_wr;

   // Next-state and per-cycle actions
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      load_bank  = 1'b0;
      load_zero  = 1'b0;
      load_res   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            case (to_hw_sig)
               CMD_WRITE: state_next = S_WLATCH;
               CMD_READ:  state_next = S_RLATCH;
               CMD_CLEAR: state_next = S_CLR;
               default:   state_next = S_IDLE;
            endcase
         end
         S_WLATCH, S_CLR: begin
            if (capture_ok) begin
               load_bank  = 1'b1;
               load_zero  = (state_reg == S_CLR);
               state_next = S_WACK;
               cnt_next   = '0;
            end
         end
         S_RLATCH: begin
            load_res   = 1'b1;
            state_next = S_RACK;
            cnt_next   = '0;
         end
         S_WACK: begin
            if (to_hw_sig == CMD_IDLE)
               state_next = S_IDLE;
            else if (to_hw_sig == CMD_READ || to_hw_sig == CMD_CLEAR)
               state_next = S_ERR;
            else if (cnt_reg == CNT_LAST)
               state_next = S_ERR;
            else
               cnt_next = cnt_reg + 1'b1;
         end
         S_RACK: begin
            if (to_hw_sig == CMD_IDLE)
               state_next = S_IDLE;
            else if (to_hw_sig == CMD_WRITE || to_hw_sig == CMD_CLEAR)
               state_next = S_ERR;
            else if (cnt_reg == CNT_LAST)
               state_next = S_ERR;
            else
               cnt_next = cnt_reg + 1'b1;
         end
         S_ERR: begin
            if (to_hw_sig == CMD_IDLE)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      err_entry = (state_next == S_ERR) && (state_reg != S_ERR);
   end

   // Status is encoded from the next state so it changes on the same edge as the state
   always_comb begin
      sig_next = ST_IDLE;
      case (state_next)
         S_WACK:  sig_next = ST_ACK;
         S_RACK:  sig_next = ST_RVALID;
         S_ERR:   sig_next = ST_ERR;
         default: sig_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_reg       <= S_IDLE;
         cnt_reg         <= '0;
         to_sw_sig_reg   <= ST_IDLE;
         busy_reg        <= 1'b0;
         err_count_reg   <= '0;
         port0_reg       <= '0;
         port1_reg       <= '0;
         port2_reg       <= '0;
         bank_update_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         to_sw_sig_reg   <= sig_next;
         busy_reg        <= (state_next != S_IDLE);
         bank_update_reg <= bank_wr;
         if (err_entry && (err_count_reg != '1))
            err_count_reg <= err_count_reg + 1'b1;
         if (load_res) begin
            port0_reg <= res0_in;
            port1_reg <= res1_in;
            port2_reg <= res2_in;
         end
      end
   end

`ifdef MBOX_DOUBLE_BUFFER_EN
   logic pend_valid_reg;
   logic unused_bank_lock;

   assign unused_bank_lock = bank_lock;
   assign capture_ok       = 1'b1;
   // A load coinciding with frame_sync goes straight through to bank_out
   assign bank_wr          = frame_sync && (pend_valid_reg || load_bank);

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n)
         pend_valid_reg <= 1'b0;
      else if (bank_wr)
         pend_valid_reg <= 1'b0;
      else if (load_bank)
         pend_valid_reg <= 1'b1;
   end
`else
   logic unused_frame_sync;

   assign unused_frame_sync = frame_sync;
   assign capture_ok        = !bank_lock;
   assign bank_wr           = load_bank;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_word
         logic [DATA_W-1:0] load_word;
         logic [DATA_W-1:0] word_reg;

         assign load_word                       = load_zero ? '0 : to_hw_port_bus[gi*DATA_W +: DATA_W];
         assign bank_out[gi*DATA_W +: DATA_W]   = word_reg;
`ifdef MBOX_DOUBLE_BUFFER_EN
         logic [DATA_W-1:0] pend_reg;

         always_ff @(posedge clk_clk) begin
            if (!reset_reset_n) begin
               pend_reg <= '0;
               word_reg <= '0;
            end else begin
               if (load_bank)
                  pend_reg <= load_word;
               if (bank_wr)
                  word_reg <= load_bank ? load_word : pend_reg;
            end
         end
`else
         always_ff @(posedge clk_clk) begin
            if (!reset_reset_n)
               word_reg <= '0;
            else if (bank_wr)
               word_reg <= load_word;
         end
`endif
      end
   endgenerate

   assign to_sw_sig   = to_sw_sig_reg;
   assign to_sw_port0 = port0_reg;
   assign to_sw_port1 = port1_reg;
   assign to_sw_port2 = port2_reg;
   assign bank_update = bank_update_reg;
   assign busy        = busy_reg;
   assign err_count   = err_count_reg;

endmodule

// File: tb/tb_sw_mailbox_ctrl.sv
// tb_sw_mailbox_ctrl: directed handshake scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the mailbox rules.
module tb_sw_mailbox_ctrl;

   localparam int TO = 16;
`ifdef MBOX_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   localparam int JOB_NONE  = 0;
   localparam int JOB_WRITE = 1;
   localparam int JOB_CLEAR = 2;
   localparam int JOB_READ  = 3;

   logic          clk;
   logic          rst_n;
   logic [1:0]    sig;
   logic [511:0]  bus;
   logic [31:0]   res0, res1;
   logic [7:0]    res2;
   logic          lock;
   logic          fs;

   logic [1:0]    sw_sig;
   logic [31:0]   p0, p1;
   logic [7:0]    p2;
   logic [511:0]  bank;
   logic          upd;
   logic          busy_o;
   logic [7:0]    errc;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model state: what software should see, not how the hardware sequences it
   logic [1:0]  m_sig;
   int          m_job;
   int          m_age;
   logic [31:0] m_bank [16];
   logic [31:0] m_pend [16];
   bit          m_has_pend;
   logic [31:0] m_p0, m_p1;
   logic [7:0]  m_p2;
   bit          m_upd;
   int          m_err;

   sw_mailbox_ctrl #(
      .NUM_PORTS(16),
      .DATA_W(32),
      .TIMEOUT_CYCLES(TO),
      .ERRCNT_W(8)
   ) dut (
      .clk_clk(clk),
      .reset_reset_n(rst_n),
      .to_hw_sig(sig),
      .to_hw_port_bus(bus),
      .res0_in(res0),
      .res1_in(res1),
      .res2_in(res2),
      .bank_lock(lock),
      .frame_sync(fs),
      .to_sw_sig(sw_sig),
      .to_sw_port0(p0),
      .to_sw_port1(p1),
      .to_sw_port2(p2),
      .bank_out(bank),
      .bank_update(upd),
      .busy(busy_o),
      .err_count(errc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit wrote;
      bit fault;
      logic [31:0] w;
      wrote = 1'b0;
      fault = 1'b0;
      if (!rst_n) begin
         m_sig = 2'b00; m_job = JOB_NONE; m_age = 0; m_has_pend = 1'b0;
         m_upd = 1'b0; m_err = 0; m_p0 = '0; m_p1 = '0; m_p2 = '0;
         for (int i = 0; i < 16; i++) begin
            m_bank[i] = '0;
            m_pend[i] = '0;
         end
         return;
      end
      if (m_job == JOB_NONE && m_sig == 2'b00) begin
         if (sig == 2'b01)      m_job = JOB_WRITE;
         else if (sig == 2'b10) m_job = JOB_READ;
         else if (sig == 2'b11) m_job = JOB_CLEAR;
      end else if (m_job == JOB_WRITE || m_job == JOB_CLEAR) begin
         if (DB || !lock) begin
            for (int i = 0; i < 16; i++) begin
               w = (m_job == JOB_WRITE) ? bus[i*32 +: 32] : 32'd0;
               if (DB) m_pend[i] = w;
               else    m_bank[i] = w;
            end
            if (DB) m_has_pend = 1'b1;
            else    wrote = 1'b1;
            m_job = JOB_NONE; m_sig = 2'b01; m_age = 0;
         end
      end else if (m_job == JOB_READ) begin
         m_p0 = res0; m_p1 = res1; m_p2 = res2;
         m_job = JOB_NONE; m_sig = 2'b10; m_age = 0;
      end else if (m_sig == 2'b11) begin
         if (sig == 2'b00) m_sig = 2'b00;
      end else begin
         // Acknowledging: only release (00) or repeating our own code is legal
         if (sig == 2'b00)           m_sig = 2'b00;
         else if (sig != m_sig)      fault = 1'b1;
         else if (m_age == TO - 1)   fault = 1'b1;
         else                        m_age++;
      end
      if (fault) begin
         m_sig = 2'b11;
         if (m_err < 255) m_err++;
      end
      if (DB && fs && m_has_pend) begin
         for (int i = 0; i < 16; i++) m_bank[i] = m_pend[i];
         m_has_pend = 1'b0;
         wrote = 1'b1;
      end
      m_upd = wrote;
   endtask

   task automatic compare_all();
      logic [511:0] mf;
      for (int i = 0; i < 16; i++) mf[i*32 +: 32] = m_bank[i];
      cmp("to_sw_sig", sw_sig, m_sig);
      cmp("busy", busy_o, (m_job != JOB_NONE) || (m_sig != 2'b00));
      cmp("bank_out", bank, mf);
      cmp("bank_update", upd, m_upd);
      cmp("to_sw_port0", p0, m_p0);
      cmp("to_sw_port1", p1, m_p1);
      cmp("to_sw_port2", p2, m_p2);
      cmp("err_count", errc, m_err[7:0]);
   endtask

   initial begin : model_proc
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin : compare_proc
      forever begin
         @(negedge clk);
         if (chk_en) compare_all();
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_sig(input logic [1:0] v, input int budget);
      int n;
      n = 0;
      while (sw_sig !== v && n < budget) begin
         tick();
         n++;
      end
      cmp("wait_sig", sw_sig, v);
   endtask

   initial begin : stim
      int k;
      rst_n = 1'b0; sig = 2'b00; bus = '0; res0 = '0; res1 = '0; res2 = '0;
      lock = 1'b0; fs = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      chk_en = 1'b1;
      cmp("reset_sig", sw_sig, 2'b00);
      cmp("reset_busy", busy_o, 1'b0);
      cmp("reset_bank", bank, 512'd0);
      cmp("reset_err", errc, 8'd0);

      // Write: fs held high so the double-buffered build shows the same timing
      bus = '0;
      bus[31:0]    = 32'hDEAD_BEEF;
      bus[511:480] = 32'h0000_0001;
      sig = 2'b01; fs = 1'b1;
      tick();
      cmp("wr_latch_busy", busy_o, 1'b1);
      cmp("wr_latch_sig", sw_sig, 2'b00);
      tick();
      cmp("wr_ack_sig", sw_sig, 2'b01);
      cmp("wr_word0", bank[31:0], 32'hDEAD_BEEF);
      cmp("wr_word15", bank[511:480], 32'h0000_0001);
      cmp("wr_update_hi", upd, 1'b1);
      tick();
      cmp("wr_update_lo", upd, 1'b0);
      sig = 2'b00; fs = 1'b0;
      tick();
      cmp("wr_release_sig", sw_sig, 2'b00);
      cmp("wr_release_busy", busy_o, 1'b0);
      $display("write: word0=%h word15=%h", bank[31:0], bank[511:480]);

      // Lock stall
      bus[31:0] = 32'h1234_5678;
      lock = 1'b1; sig = 2'b01;
      for (int i = 0; i < 10; i++) begin
         tick();
         cmp("stall_bank", bank[31:0], 32'hDEAD_BEEF);
`ifndef MBOX_DOUBLE_BUFFER_EN
         cmp("stall_sig", sw_sig, 2'b00);
`endif
      end
      lock = 1'b0;
      tick();
`ifndef MBOX_DOUBLE_BUFFER_EN
      cmp("stall_capture", bank[31:0], 32'h1234_5678);
      cmp("stall_ack", sw_sig, 2'b01);
`endif
      sig = 2'b00;
      tick();
      $display("stall write: word0=%h sig=%0d", bank[31:0], sw_sig);

      // Read, then results change while RACK is held
      res0 = 32'd1234; res1 = 32'hCAFE_0001; res2 = 8'h5A; sig = 2'b10;
      repeat (2) tick();
      cmp("rd_sig", sw_sig, 2'b10);
      cmp("rd_port0", p0, 32'd1234);
      cmp("rd_port2", p2, 8'h5A);
      res0 = 32'd999; res2 = 8'h00;
      repeat (3) tick();
      cmp("rd_hold_port0", p0, 32'd1234);
      cmp("rd_hold_port2", p2, 8'h5A);
      cmp("rd_hold_sig", sw_sig, 2'b10);
      sig = 2'b00;
      tick();
      cmp("rd_release", sw_sig, 2'b00);
      $display("read: port0=%0d port2=%h", p0, p2);

      // Protocol violations until err_count saturates
      for (int i = 0; i < 300; i++) begin
         sig = 2'b01;
         wait_sig(2'b01, 20);
         sig = 2'b10;
         tick();
         cmp("viol_sig", sw_sig, 2'b11);
         if (i == 0) cmp("viol_first_count", errc, 8'd1);
         sig = 2'b00;
         tick();
         cmp("viol_release", sw_sig, 2'b00);
      end
      cmp("viol_saturate", errc, 8'd255);
      $display("violations: err_count=%0d", errc);

      // Timeout while software keeps sig=01 after the ack
      sig = 2'b01;
      wait_sig(2'b01, 20);
      k = 0;
      while (sw_sig == 2'b01 && k < 40) begin
         tick();
         k++;
      end
      cmp("timeout_cycles", k, 16);
      cmp("timeout_sig", sw_sig, 2'b11);
      sig = 2'b00;
      tick();
      cmp("timeout_release", sw_sig, 2'b00);
      $display("timeout: cycles_in_ack=%0d", k);

      // Reset in the middle of an ack
      sig = 2'b01;
      wait_sig(2'b01, 20);
      rst_n = 1'b0; sig = 2'b00;
      tick();
      rst_n = 1'b1;
      cmp("rst_sig", sw_sig, 2'b00);
      cmp("rst_busy", busy_o, 1'b0);
      cmp("rst_bank", bank, 512'd0);
      cmp("rst_err", errc, 8'd0);
      cmp("rst_port0", p0, 32'd0);
      cmp("rst_update", upd, 1'b0);
      $display("reset mid-ack: sig=%0d busy=%0d", sw_sig, busy_o);

      // Randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 25) begin
            if ($urandom_range(0, 9) < 4) sig = 2'b00;
            else                         sig = 2'($urandom_range(0, 3));
         end
         lock  = ($urandom_range(0, 3) == 0);
         fs    = ($urandom_range(0, 7) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < 16; i++)
            if ($urandom_range(0, 3) == 0) bus[i*32 +: 32] = $urandom;
         res0 = $urandom;
         res1 = $urandom;
         res2 = 8'($urandom);
         tick();
      end
      rst_n = 1'b1;
      sig = 2'b00;
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
